reg_access_arb: RTL and testbench

REG_ACCESS_ARB -- requirements
Module: reg_access_arb

---
 rtl/reg_access_arb.sv | 158 +++++++++++++++
 tb/tb_reg_access_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arb.sv
// reg_access_arb: round-robin arbiter giving an I2C slave and a local engine
// four-phase access to a 16-register status bank. Rev 1.0
`default_nettype none

module reg_access_arb #(
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        I2C_REQ,
  input  logic        I2C_RD_WR,
  input  logic [7:0]  I2C_ADDR,
  input  logic [7:0]  I2C_WDATA,
  output logic        I2C_ACK,
  output logic [7:0]  I2C_RDATA,
  input  logic        LOC_REQ,
  input  logic        LOC_RD_WR,
  input  logic [7:0]  LOC_ADDR,
  input  logic [7:0]  LOC_WDATA,
  output logic        LOC_ACK,
  output logic [7:0]  LOC_RDATA,
  output logic        PORT_CS,
  output logic        RD_WR,
  output logic [15:0] OFFSET_SEL,
  output logic [7:0]  BANK_DIN,
  input  logic [7:0]  BANK_DOUT,
  input  logic        CLR_ERR,
  output logic        BUSY,
  output logic        ERR,
  output logic        GRANT
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    CAPTURE  = 2'd2,
    ACK_WAIT = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_ptr;
  logic        r_rw;
  logic        r_inrange;
  logic [7:0]  r_cnt;
  logic [1:0]  r_blk;

  logic        w_req0;
  logic        w_req1;
  logic        w_sel;
  logic        w_rw;
  logic [7:0]  w_addr;
  logic [7:0]  w_wdata;
  logic        w_inrange;
  logic [3:0]  w_off;
  logic [15:0] w_onehot;
  logic        w_gnt_req;

  // A requester that timed out stays masked until it drops REQ.
  assign w_req0    = I2C_REQ & ~r_blk[0];
  assign w_req1    = LOC_REQ & ~r_blk[1];
  assign w_sel     = (w_req0 & w_req1) ? r_ptr : w_req1;
  assign w_rw      = w_sel ? LOC_RD_WR : I2C_RD_WR;
  assign w_addr    = w_sel ? LOC_ADDR  : I2C_ADDR;
  assign w_wdata   = w_sel ? LOC_WDATA : I2C_WDATA;
  assign w_inrange = (w_addr >= BASE_ADDR) &&
                     ({1'b0, w_addr} <= ({1'b0, BASE_ADDR} + 9'd15));
  assign w_off     = w_addr[3:0] - BASE_ADDR[3:0];
  assign w_onehot  = 16'h0001 << w_off;
  assign w_gnt_req = GRANT ? LOC_REQ : I2C_REQ;
  assign BUSY      = (r_state != IDLE);

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_rw       <= 1'b1;
      r_inrange  <= 1'b0;
      r_cnt      <= 8'h00;
      r_blk      <= 2'b00;
      GRANT      <= 1'b0;
      PORT_CS    <= 1'b0;
      OFFSET_SEL <= 16'h0000;
      RD_WR      <= 1'b1;
      BANK_DIN   <= 8'h00;
      I2C_ACK    <= 1'b0;
      LOC_ACK    <= 1'b0;
      I2C_RDATA  <= 8'h00;
      LOC_RDATA  <= 8'h00;
      ERR        <= 1'b0;
    end else begin
      r_blk      <= r_blk & {LOC_REQ, I2C_REQ};
      PORT_CS    <= 1'b0;
      OFFSET_SEL <= 16'h0000;
      RD_WR      <= 1'b1;
      BANK_DIN   <= 8'h00;
      if (CLR_ERR) ERR <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= 8'h00;
          if (w_req0 | w_req1) begin
            r_state   <= ACCESS;
            GRANT     <= w_sel;
            r_rw      <= w_rw;
            r_inrange <= w_inrange;
            // Bank strobes are registered here so they are live exactly for the ACCESS cycle.
            if (w_inrange) begin
              PORT_CS    <= 1'b1;
              OFFSET_SEL <= w_onehot;
              RD_WR      <= w_rw;
              BANK_DIN   <= w_rw ? 8'h00 : w_wdata;
            end
          end
        end
        ACCESS: begin
          r_state <= CAPTURE;
          if (!r_inrange) ERR <= 1'b1;
        end
        CAPTURE: begin
          r_state <= ACK_WAIT;
          r_cnt   <= 8'h00;
          if (GRANT) begin
            LOC_ACK <= 1'b1;
            if (!r_inrange)  LOC_RDATA <= 8'hFF;
            else if (r_rw)   LOC_RDATA <= BANK_DOUT;
          end else begin
            I2C_ACK <= 1'b1;
            if (!r_inrange)  I2C_RDATA <= 8'hFF;
            else if (r_rw)   I2C_RDATA <= BANK_DOUT;
          end
        end
        ACK_WAIT: begin
          if (!w_gnt_req) begin
            r_state <= IDLE;
            r_ptr   <= ~GRANT;
            I2C_ACK <= 1'b0;
            LOC_ACK <= 1'b0;
          end else if (r_cnt == (TIMEOUT - 8'd1)) begin
            r_state <= IDLE;
            r_ptr   <= ~GRANT;
            I2C_ACK <= 1'b0;
            LOC_ACK <= 1'b0;
            ERR     <= 1'b1;
            if (GRANT) r_blk[1] <= 1'b1;
            else       r_blk[0] <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_access_arb.sv
// tb_reg_access_arb: directed scenario bench for reg_access_arb. Rev 1.0
`default_nettype none

module tb_reg_access_arb;

  logic        SYSCLK;
  logic        RESET_N;
  logic        I2C_REQ, I2C_RD_WR, LOC_REQ, LOC_RD_WR, CLR_ERR;
  logic [7:0]  I2C_ADDR, I2C_WDATA, LOC_ADDR, LOC_WDATA, BANK_DOUT;
  logic        I2C_ACK, LOC_ACK, PORT_CS, RD_WR, BUSY, ERR, GRANT;
  logic [7:0]  I2C_RDATA, LOC_RDATA, BANK_DIN;
  logic [15:0] OFFSET_SEL;
  logic [7:0]  bank_val;
  int          checks;
  int          errors;

  reg_access_arb dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N),
    .I2C_REQ(I2C_REQ), .I2C_RD_WR(I2C_RD_WR), .I2C_ADDR(I2C_ADDR), .I2C_WDATA(I2C_WDATA),
    .I2C_ACK(I2C_ACK), .I2C_RDATA(I2C_RDATA),
    .LOC_REQ(LOC_REQ), .LOC_RD_WR(LOC_RD_WR), .LOC_ADDR(LOC_ADDR), .LOC_WDATA(LOC_WDATA),
    .LOC_ACK(LOC_ACK), .LOC_RDATA(LOC_RDATA),
    .PORT_CS(PORT_CS), .RD_WR(RD_WR), .OFFSET_SEL(OFFSET_SEL), .BANK_DIN(BANK_DIN),
    .BANK_DOUT(BANK_DOUT), .CLR_ERR(CLR_ERR), .BUSY(BUSY), .ERR(ERR), .GRANT(GRANT)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  // Bank model: registered read data, valid only the cycle after a read strobe.
  always @(posedge SYSCLK) BANK_DOUT <= (PORT_CS && RD_WR) ? bank_val : 8'h00;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (I2C_ACK !== 1'b0 || LOC_ACK !== 1'b0) begin errors++; $display("FAIL rst_ack got %b%b want 00", LOC_ACK, I2C_ACK); end
    checks++; if (I2C_RDATA !== 8'h00 || LOC_RDATA !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h %h want 00 00", I2C_RDATA, LOC_RDATA); end
    checks++; if (PORT_CS !== 1'b0 || RD_WR !== 1'b1 || OFFSET_SEL !== 16'h0 || BANK_DIN !== 8'h00) begin errors++; $display("FAIL rst_bank got cs=%b rw=%b sel=%h din=%h want 0 1 0000 00", PORT_CS, RD_WR, OFFSET_SEL, BANK_DIN); end
    checks++; if (BUSY !== 1'b0 || ERR !== 1'b0 || GRANT !== 1'b0) begin errors++; $display("FAIL rst_status got busy=%b err=%b gnt=%b want 0 0 0", BUSY, ERR, GRANT); end
    RESET_N = 1'b1;
  endtask

  task automatic test_read();
    bank_val = 8'h3C; I2C_RD_WR = 1'b1; I2C_ADDR = 8'hA5; I2C_REQ = 1'b1;
    tick();
    checks++; if (PORT_CS !== 1'b1 || RD_WR !== 1'b1 || OFFSET_SEL !== 16'h0020) begin errors++; $display("FAIL rd_access got cs=%b rw=%b sel=%h want 1 1 0020", PORT_CS, RD_WR, OFFSET_SEL); end
    checks++; if (BUSY !== 1'b1 || GRANT !== 1'b0) begin errors++; $display("FAIL rd_busy got busy=%b gnt=%b want 1 0", BUSY, GRANT); end
    I2C_RD_WR = 1'b0; I2C_ADDR = 8'h10;
    tick();
    checks++; if (PORT_CS !== 1'b0 || OFFSET_SEL !== 16'h0 || I2C_ACK !== 1'b0) begin errors++; $display("FAIL rd_capture got cs=%b sel=%h ack=%b want 0 0000 0", PORT_CS, OFFSET_SEL, I2C_ACK); end
    tick();
    checks++; if (I2C_ACK !== 1'b1 || I2C_RDATA !== 8'h3C) begin errors++; $display("FAIL rd_ack got ack=%b rdata=%h want 1 3c", I2C_ACK, I2C_RDATA); end
    tick(); tick();
    checks++; if (I2C_ACK !== 1'b1 || LOC_ACK !== 1'b0 || I2C_RDATA !== 8'h3C || ERR !== 1'b0) begin errors++; $display("FAIL rd_hold got ack=%b lack=%b rdata=%h err=%b want 1 0 3c 0", I2C_ACK, LOC_ACK, I2C_RDATA, ERR); end
    I2C_REQ = 1'b0;
    tick();
    checks++; if (I2C_ACK !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL rd_release got ack=%b busy=%b want 0 0", I2C_ACK, BUSY); end
  endtask

  task automatic test_write();
    LOC_RD_WR = 1'b0; LOC_ADDR = 8'hA6; LOC_WDATA = 8'h81; LOC_REQ = 1'b1;
    tick();
    checks++; if (PORT_CS !== 1'b1 || RD_WR !== 1'b0 || BANK_DIN !== 8'h81 || OFFSET_SEL !== 16'h0040) begin errors++; $display("FAIL wr_access got cs=%b rw=%b din=%h sel=%h want 1 0 81 0040", PORT_CS, RD_WR, BANK_DIN, OFFSET_SEL); end
    checks++; if (GRANT !== 1'b1) begin errors++; $display("FAIL wr_grant got %b want 1", GRANT); end
    tick();
    checks++; if (LOC_ACK !== 1'b0 || BANK_DIN !== 8'h00 || RD_WR !== 1'b1) begin errors++; $display("FAIL wr_capture got ack=%b din=%h rw=%b want 0 00 1", LOC_ACK, BANK_DIN, RD_WR); end
    tick();
    checks++; if (LOC_ACK !== 1'b1 || I2C_ACK !== 1'b0 || LOC_RDATA !== 8'h00) begin errors++; $display("FAIL wr_ack got lack=%b iack=%b rdata=%h want 1 0 00", LOC_ACK, I2C_ACK, LOC_RDATA); end
    LOC_REQ = 1'b0;
    tick();
    checks++; if (LOC_ACK !== 1'b0) begin errors++; $display("FAIL wr_release got %b want 0", LOC_ACK); end
  endtask

  task automatic test_range();
    logic [7:0]  addr [4];
    logic        cs   [4];
    logic [15:0] sel  [4];
    logic [7:0]  rd   [4];
    addr[0] = 8'h9F; cs[0] = 1'b0; sel[0] = 16'h0000; rd[0] = 8'hFF;
    addr[1] = 8'hA0; cs[1] = 1'b1; sel[1] = 16'h0001; rd[1] = 8'h5A;
    addr[2] = 8'hAF; cs[2] = 1'b1; sel[2] = 16'h8000; rd[2] = 8'h5A;
    addr[3] = 8'h10; cs[3] = 1'b0; sel[3] = 16'h0000; rd[3] = 8'hFF;
    bank_val = 8'h5A; I2C_RD_WR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      I2C_ADDR = addr[i]; I2C_REQ = 1'b1;
      tick();
      checks++; if (PORT_CS !== cs[i] || OFFSET_SEL !== sel[i]) begin errors++; $display("FAIL range_sel[%0d] got cs=%b sel=%h want %b %h", i, PORT_CS, OFFSET_SEL, cs[i], sel[i]); end
      tick(); tick();
      checks++; if (I2C_ACK !== 1'b1 || I2C_RDATA !== rd[i] || ERR !== ~cs[i]) begin errors++; $display("FAIL range_ack[%0d] got ack=%b rdata=%h err=%b want 1 %h %b", i, I2C_ACK, I2C_RDATA, ERR, rd[i], ~cs[i]); end
      I2C_REQ = 1'b0;
      tick();
      if (ERR) begin
        CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL range_clr[%0d] got %b want 0", i, ERR); end
      end
    end
  endtask

  task automatic test_err_priority();
    CLR_ERR = 1'b1; I2C_RD_WR = 1'b1; I2C_ADDR = 8'h10; I2C_REQ = 1'b1;
    tick(); tick();
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", ERR); end
    tick();
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err_clr_after got %b want 0", ERR); end
    CLR_ERR = 1'b0;
    tick();
    I2C_REQ = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    logic       got;
    exp_g = 3'b010;
    RESET_N = 1'b0; #2; RESET_N = 1'b1;
    bank_val = 8'h11;
    I2C_RD_WR = 1'b1; I2C_ADDR = 8'hA1; LOC_RD_WR = 1'b1; LOC_ADDR = 8'hA2;
    I2C_REQ = 1'b1; LOC_REQ = 1'b1;
    for (int t = 0; t < 3; t++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        tick();
        if (I2C_ACK || LOC_ACK) got = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL rr_wait[%0d] got no ack want ack", t); end
      checks++; if (GRANT !== exp_g[t]) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", t, GRANT, exp_g[t]); end
      checks++; if ({LOC_ACK, I2C_ACK} !== (exp_g[t] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ack[%0d] got %b%b want %b", t, LOC_ACK, I2C_ACK, exp_g[t] ? 2'b10 : 2'b01); end
      if (I2C_ACK) I2C_REQ = 1'b0; else LOC_REQ = 1'b0;
      tick();
      I2C_REQ = 1'b1; LOC_REQ = 1'b1;
    end
    I2C_REQ = 1'b0; LOC_REQ = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int  cnt;
    logic got;
    logic stray;
    bank_val = 8'h77; LOC_RD_WR = 1'b1; LOC_ADDR = 8'hA3; LOC_REQ = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin tick(); if (LOC_ACK) got = 1'b1; end
    checks++; if (!got) begin errors++; $display("FAIL to_first_ack got none want ack"); end
    cnt = got ? 1 : 0;
    for (int k = 0; k < 300 && LOC_ACK; k++) begin tick(); if (LOC_ACK) cnt++; end
    checks++; if (cnt != 255) begin errors++; $display("FAIL to_ack_cycles got %0d want 255", cnt); end
    checks++; if (ERR !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL to_err got err=%b busy=%b want 1 0", ERR, BUSY); end
    stray = 1'b0;
    for (int k = 0; k < 20; k++) begin tick(); if (LOC_ACK || BUSY) stray = 1'b1; end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL to_no_reserve got %b want 0", stray); end
    LOC_REQ = 1'b0; tick(); LOC_REQ = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin tick(); if (LOC_ACK) got = 1'b1; end
    checks++; if (!got || LOC_RDATA !== 8'h77) begin errors++; $display("FAIL to_reserve got ack=%b rdata=%h want 1 77", got, LOC_RDATA); end
  endtask

  task automatic test_reset_mid();
    LOC_REQ = 1'b0; tick();
    LOC_ADDR = 8'hA4; LOC_REQ = 1'b1;
    tick(); tick();
    checks++; if (GRANT !== 1'b1 || BUSY !== 1'b1 || ERR !== 1'b1) begin errors++; $display("FAIL mid_pre got gnt=%b busy=%b err=%b want 1 1 1", GRANT, BUSY, ERR); end
    RESET_N = 1'b0; #1;
    checks++; if (GRANT !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0 || LOC_ACK !== 1'b0 || LOC_RDATA !== 8'h00) begin errors++; $display("FAIL mid_rst got gnt=%b busy=%b err=%b ack=%b rdata=%h want 0 0 0 0 00", GRANT, BUSY, ERR, LOC_ACK, LOC_RDATA); end
    LOC_REQ = 1'b0;
    tick();
    RESET_N = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++; if (LOC_ACK !== 1'b0 || I2C_ACK !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL mid_after got lack=%b iack=%b busy=%b want 0 0 0", LOC_ACK, I2C_ACK, BUSY); end
  endtask

  initial begin
    checks = 0; errors = 0;
    RESET_N = 1'b0; CLR_ERR = 1'b0; bank_val = 8'h00;
    I2C_REQ = 1'b0; I2C_RD_WR = 1'b1; I2C_ADDR = 8'h00; I2C_WDATA = 8'h00;
    LOC_REQ = 1'b0; LOC_RD_WR = 1'b1; LOC_ADDR = 8'h00; LOC_WDATA = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_range();
    test_err_priority();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
